web1_lp_seq: RTL and testbench

WEB1_LP_SEQ -- requirements
Module: web1_lp_seq

---
 rtl/web1_lp_seq_pkg.sv | 31 +++
 rtl/web1_lp_pulse_gen.sv | 93 +++++++++
 rtl/web1_lp_seq.sv | 163 ++++++++++++++++
 tb/tb_web1_lp_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/web1_lp_seq_pkg.sv
// Shared types and default constants for the web1 low-power sequencer.
package web1_lp_seq_pkg;

  localparam int ENTRY_DLY_DEF = 16;
  localparam int CLR_CYC_DEF   = 4;
  localparam int ACK_TMO_DEF   = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_REQ   = 3'd2,
    ST_SLEEP = 3'd3,
    ST_EXIT  = 3'd4
  } lp_state_e;

  typedef enum logic [1:0] {
    PG_IDLE = 2'd0,
    PG_HIGH = 2'd1,
    PG_GAP  = 2'd2
  } pg_state_e;

  // Saturating increment; callers truncate the result to their counter width.
  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned max_val);
    if (cnt >= max_val) begin
      return max_val;
    end else begin
      return cnt + 32'd1;
    end
  endfunction

endpackage

// File: rtl/web1_lp_pulse_gen.sv
// Clear-pulse generator: CLR_CYC cycles high, at least CLR_CYC cycles low,
// with a one-deep request queue into which further requests merge.
module web1_lp_pulse_gen
  import web1_lp_seq_pkg::*;
#(
  parameter int CLR_CYC = CLR_CYC_DEF
) (
  input  logic clkclk,
  input  logic sysreset_n,
  input  logic pulse_req,
  output logic clear_function
);

  localparam int CNT_W = $clog2(CLR_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_CYC - 1);

  pg_state_e        pg_state_q, pg_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             queued_q, queued_d;
  logic             clr_q, clr_d;

  // Pulse sequencing: high phase, low gap, then launch any queued request
  always_comb begin
    pg_state_d = pg_state_q;
    cnt_d      = '0;
    queued_d   = queued_q;
    clr_d      = 1'b0;
    case (pg_state_q)
      PG_IDLE: begin
        queued_d = 1'b0;
        if (pulse_req) begin
          pg_state_d = PG_HIGH;
          clr_d      = 1'b1;
        end else begin
          pg_state_d = PG_IDLE;
        end
      end
      PG_HIGH: begin
        if (pulse_req) begin
          queued_d = 1'b1;
        end else begin
          queued_d = queued_q;
        end
        if (cnt_q >= CNT_LAST) begin
          pg_state_d = PG_GAP;
        end else begin
          cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CLR_CYC)));
          clr_d = 1'b1;
        end
      end
      PG_GAP: begin
        if (cnt_q >= CNT_LAST) begin
          queued_d = 1'b0;
          if (queued_q || pulse_req) begin
            pg_state_d = PG_HIGH;
            clr_d      = 1'b1;
          end else begin
            pg_state_d = PG_IDLE;
          end
        end else begin
          cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CLR_CYC)));
          if (pulse_req) begin
            queued_d = 1'b1;
          end else begin
            queued_d = queued_q;
          end
        end
      end
      default: begin
        pg_state_d = PG_IDLE;
        queued_d   = 1'b0;
      end
    endcase
  end

  // Pulse state, phase counter, queue bit and registered output
  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      pg_state_q <= PG_IDLE;
      cnt_q      <= '0;
      queued_q   <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      pg_state_q <= pg_state_d;
      cnt_q      <= cnt_d;
      queued_q   <= queued_d;
      clr_q      <= clr_d;
    end
  end

  assign clear_function = clr_q;

endmodule

// File: rtl/web1_lp_seq.sv
// Low-power entry/exit sequencer for the web1 wake-enable path.
// Define WEB1_LP_SEQ_TIMEOUT_EN to enable the pwr_ack handshake timeout.
module web1_lp_seq
  import web1_lp_seq_pkg::*;
#(
  parameter int ENTRY_DLY = ENTRY_DLY_DEF,
  parameter int CLR_CYC   = CLR_CYC_DEF,
  parameter int ACK_TMO   = ACK_TMO_DEF
) (
  input  logic       clkclk,
  input  logic       sysreset_n,
  input  logic       activate_low_pwr,
  input  logic       wake,
  input  logic       epu_enable,
  input  logic       pwr_ack,
  input  logic       err_clr,
  output logic       pwr_req,
  output logic       clear_function,
  output logic [2:0] lp_state,
  output logic       timeout_err
);

  localparam int DLY_W = $clog2(ENTRY_DLY + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ENTRY_DLY - 1);

  lp_state_e        state_q, state_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic             pwr_req_q, pwr_req_d;
  logic             pulse_req_s;
  logic             tmo_expired_s;

`ifdef WEB1_LP_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             tmo_fire_s;

  assign tmo_expired_s = (tmo_cnt_q >= TMO_LAST);

  // Handshake wait counter and sticky error; a new timeout outranks err_clr
  always_comb begin
    tmo_fire_s = tmo_expired_s &&
                 (((state_q == ST_REQ) && !pwr_ack) || ((state_q == ST_EXIT) && pwr_ack));
    if (((state_q == ST_REQ) || (state_q == ST_EXIT)) && (state_d == state_q)) begin
      tmo_cnt_d = TMO_W'(sat_inc(32'(tmo_cnt_q), 32'(ACK_TMO)));
    end else begin
      tmo_cnt_d = '0;
    end
    if (tmo_fire_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // Timeout counter and error flag registers
  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_cfg_s;

  assign tmo_expired_s = 1'b0;
  assign timeout_err   = 1'b0;
  assign unused_cfg_s  = err_clr ^ (ACK_TMO > 0);
`endif

  // Sequencer next state; wake is deliberately ignored in REQ so the handshake completes
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = '0;
    pulse_req_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (activate_low_pwr && epu_enable && !wake) begin
          state_d = ST_DELAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (wake || !epu_enable) begin
          state_d     = ST_IDLE;
          pulse_req_s = 1'b1;
        end else if (dly_cnt_q >= DLY_LAST) begin
          state_d = ST_REQ;
        end else begin
          state_d   = ST_DELAY;
          dly_cnt_d = DLY_W'(sat_inc(32'(dly_cnt_q), 32'(ENTRY_DLY)));
        end
      end
      ST_REQ: begin
        if (pwr_ack) begin
          state_d     = ST_SLEEP;
          pulse_req_s = 1'b1;
        end else if (tmo_expired_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SLEEP: begin
        if (wake) begin
          state_d = ST_EXIT;
        end else begin
          state_d = ST_SLEEP;
        end
      end
      ST_EXIT: begin
        if (!pwr_ack) begin
          state_d = ST_IDLE;
        end else if (tmo_expired_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Request rises one cycle after REQ is entered and falls as EXIT or IDLE is entered
    pwr_req_d = (state_d == ST_SLEEP) || ((state_q == ST_REQ) && (state_d == ST_REQ));
  end

  // Sequencer state, entry delay counter and registered power request
  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q   <= ST_IDLE;
      dly_cnt_q <= '0;
      pwr_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      pwr_req_q <= pwr_req_d;
    end
  end

  web1_lp_pulse_gen #(
    .CLR_CYC(CLR_CYC)
  ) u_pulse_gen (
    .clkclk        (clkclk),
    .sysreset_n    (sysreset_n),
    .pulse_req     (pulse_req_s),
    .clear_function(clear_function)
  );

  assign pwr_req  = pwr_req_q;
  assign lp_state = state_q;

endmodule

// File: tb/tb_web1_lp_seq.sv
// Self-checking bench for web1_lp_seq: randomized timing checked against
// expectations derived from the sequencer's cycle rules.
module tb_web1_lp_seq;

  localparam int ENTRY  = 16;
  localparam int CLR    = 4;
  localparam int TMO    = 255;
  localparam int ENTRY2 = 1;

  logic       clkclk;
  logic       sysreset_n;
  logic       act, wake, epu, ack, err_clr;
  logic       pwr_req, clear_function, timeout_err;
  logic [2:0] lp_state;
  logic       act2, wake2, epu2, ack2, err_clr2;
  logic       pwr_req2, clear2, timeout_err2;
  logic [2:0] lp_state2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  web1_lp_seq dut (
    .clkclk(clkclk), .sysreset_n(sysreset_n), .activate_low_pwr(act), .wake(wake),
    .epu_enable(epu), .pwr_ack(ack), .err_clr(err_clr), .pwr_req(pwr_req),
    .clear_function(clear_function), .lp_state(lp_state), .timeout_err(timeout_err)
  );

  web1_lp_seq #(.ENTRY_DLY(ENTRY2)) dut2 (
    .clkclk(clkclk), .sysreset_n(sysreset_n), .activate_low_pwr(act2), .wake(wake2),
    .epu_enable(epu2), .pwr_ack(ack2), .err_clr(err_clr2), .pwr_req(pwr_req2),
    .clear_function(clear2), .lp_state(lp_state2), .timeout_err(timeout_err2)
  );

  initial clkclk = 1'b0;
  always #5 clkclk = ~clkclk;

  task automatic tick();
    @(posedge clkclk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    act = 1'b0; wake = 1'b0; epu = 1'b0; ack = 1'b0; err_clr = 1'b0;
    act2 = 1'b0; wake2 = 1'b0; epu2 = 1'b0; ack2 = 1'b0; err_clr2 = 1'b0;
    sysreset_n = 1'b0;
    repeat (3) @(posedge clkclk);
    #1;
    sysreset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (lp_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", lp_state);
    else n_pass++;
    n_checks++;
    if (pwr_req !== 1'b0) $display("FAIL reset_pwr_req: got %b expected 0", pwr_req);
    else n_pass++;
    n_checks++;
    if (clear_function !== 1'b0) $display("FAIL reset_clear: got %b expected 0", clear_function);
    else n_pass++;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
    else n_pass++;
  endtask

  // Entry: ack rises lat cycles after pwr_req; ends parked in SLEEP with ack high.
  task automatic test_entry(input int lat);
    int pr_first, sl_first, clr_first, clr_hi, pr_drop;
    apply_reset();
    act = 1'b1; epu = 1'b1;
    pr_first = -1; sl_first = -1; clr_first = -1; clr_hi = 0; pr_drop = 0;
    for (int i = 0; i < ENTRY + lat + 20; i++) begin
      tick();
      if (pwr_req && pr_first < 0) pr_first = cyc;
      if (pr_first >= 0 && !pwr_req) pr_drop = 1;
      if (lp_state == 3'd3 && sl_first < 0) sl_first = cyc;
      if (clear_function) begin
        clr_hi++;
        if (clr_first < 0) clr_first = cyc;
      end
      if (pr_first >= 0 && cyc == pr_first + lat) ack = 1'b1;
    end
    n_checks++;
    if (pr_first !== ENTRY + 2) $display("FAIL entry_req_cycle: got %0d expected %0d", pr_first, ENTRY + 2);
    else n_pass++;
    n_checks++;
    if (sl_first !== ENTRY + 3 + lat) $display("FAIL entry_sleep_cycle: got %0d expected %0d", sl_first, ENTRY + 3 + lat);
    else n_pass++;
    n_checks++;
    if (clr_first !== ENTRY + 3 + lat) $display("FAIL entry_clear_start: got %0d expected %0d", clr_first, ENTRY + 3 + lat);
    else n_pass++;
    n_checks++;
    if (clr_hi !== CLR) $display("FAIL entry_clear_len: got %0d expected %0d", clr_hi, CLR);
    else n_pass++;
    n_checks++;
    if (pr_drop !== 0) $display("FAIL entry_req_held: got drop=%0d expected 0", pr_drop);
    else n_pass++;
  endtask

  // Exit from SLEEP: ack stays high for w EXIT cycles, then falls.
  task automatic test_exit(input int w);
    logic [2:0] seen[$];
    logic [2:0] exp_q[$];
    int pr_bad, nbad;
    pr_bad = 0; nbad = 0;
    wake = 1'b1;
    for (int i = 0; i < w; i++) begin
      tick();
      seen.push_back(lp_state);
      if (pwr_req) pr_bad++;
    end
    ack = 1'b0;
    tick();
    seen.push_back(lp_state);
    for (int i = 0; i < w; i++) exp_q.push_back(3'd4);
    exp_q.push_back(3'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (seen[i] !== exp_q[i]) nbad++;
    end
    n_checks++;
    if (nbad !== 0) $display("FAIL exit_seq: %0d wrong states, last got %0d expected 0", nbad, seen[seen.size()-1]);
    else n_pass++;
    n_checks++;
    if (pr_bad !== 0) $display("FAIL exit_req_low: got %0d high cycles expected 0", pr_bad);
    else n_pass++;
    wake = 1'b0; act = 1'b0;
  endtask

  // Abort during DELAY cycle k by wake (or by dropping epu_enable).
  task automatic test_abort(input int k, input bit use_wake);
    int clr_hi, rises, pr_ever;
    logic prev;
    logic [2:0] st_after;
    apply_reset();
    act = 1'b1; epu = 1'b1;
    for (int i = 0; i < k; i++) tick();
    if (use_wake) wake = 1'b1;
    else epu = 1'b0;
    act = 1'b0;
    clr_hi = 0; rises = 0; pr_ever = 0; prev = 1'b0;
    tick();
    st_after = lp_state;
    wake = 1'b0; epu = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (clear_function) clr_hi++;
      if (clear_function && !prev) rises++;
      if (pwr_req) pr_ever = 1;
      prev = clear_function;
      tick();
    end
    n_checks++;
    if (st_after !== 3'd0) $display("FAIL abort_state: got %0d expected 0", st_after);
    else n_pass++;
    n_checks++;
    if (pr_ever !== 0) $display("FAIL abort_no_req: got %0d expected 0", pr_ever);
    else n_pass++;
    n_checks++;
    if (rises !== 1 || clr_hi !== CLR) $display("FAIL abort_pulse: got %0d pulses %0d cycles expected 1 pulse %0d cycles", rises, clr_hi, CLR);
    else n_pass++;
  endtask

  // Wake raised in REQ must not withdraw the request; SLEEP then EXIT follow.
  task automatic test_wake_in_req(input int lat);
    int sl_first, saw_idle;
    logic [2:0] st_next;
    apply_reset();
    act = 1'b1; epu = 1'b1;
    for (int i = 0; i < ENTRY + 1; i++) tick();
    wake = 1'b1;
    sl_first = -1; saw_idle = 0; st_next = 3'd7;
    for (int i = 0; i < lat + 6; i++) begin
      if (cyc == ENTRY + 2 + lat) ack = 1'b1;
      tick();
      if (sl_first < 0 && lp_state == 3'd0) saw_idle = 1;
      if (sl_first >= 0 && cyc == sl_first + 1) st_next = lp_state;
      if (lp_state == 3'd3 && sl_first < 0) sl_first = cyc;
    end
    n_checks++;
    if (saw_idle !== 0 || sl_first !== ENTRY + 3 + lat) $display("FAIL wake_in_req_sleep: got sleep at %0d idle=%0d expected sleep at %0d", sl_first, saw_idle, ENTRY + 3 + lat);
    else n_pass++;
    n_checks++;
    if (st_next !== 3'd4) $display("FAIL wake_in_req_exit: got %0d expected 4", st_next);
    else n_pass++;
  endtask

  // Abort pulse followed by a SLEEP-entry pulse request x cycles later (short-delay instance).
  task automatic test_queue(input int x);
    int rises[$];
    int hi, sl, s1, s2, exp_sl;
    logic prev;
    apply_reset();
    act2 = 1'b1; epu2 = 1'b1; ack2 = 1'b1;
    hi = 0; sl = -1; prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (cyc == 1) wake2 = 1'b1;
      else if (cyc == 2 + x) wake2 = 1'b0;
      tick();
      if (clear2 && !prev) rises.push_back(cyc);
      if (clear2) hi++;
      prev = clear2;
      if (lp_state2 == 3'd3 && sl < 0) sl = cyc;
    end
    exp_sl = 3 + x + ENTRY2 + 1;
    s1 = 2;
    s2 = (exp_sl > s1 + 2 * CLR) ? exp_sl : s1 + 2 * CLR;
    n_checks++;
    if (sl !== exp_sl) $display("FAIL queue_sleep_cycle: got %0d expected %0d", sl, exp_sl);
    else n_pass++;
    n_checks++;
    if (rises.size() !== 2 || hi !== 2 * CLR) $display("FAIL queue_pulse_count: got %0d pulses %0d cycles expected 2 pulses %0d cycles", rises.size(), hi, 2 * CLR);
    else n_pass++;
    n_checks++;
    if (rises.size() < 2) $display("FAIL queue_second_start: got no second pulse expected start %0d", s2);
    else if (rises[0] !== s1 || rises[1] !== s2) $display("FAIL queue_second_start: got %0d,%0d expected %0d,%0d", rises[0], rises[1], s1, s2);
    else n_pass++;
    act2 = 1'b0;
  endtask

  // Asynchronous reset while in SLEEP with the clear pulse active.
  task automatic test_reset_in_sleep();
    int reached;
    apply_reset();
    act2 = 1'b1; epu2 = 1'b1; ack2 = 1'b1;
    reached = 0;
    for (int i = 0; i < 20 && reached == 0; i++) begin
      tick();
      if (lp_state2 == 3'd3) reached = 1;
    end
    n_checks++;
    if (reached !== 1 || pwr_req2 !== 1'b1 || clear2 !== 1'b1) $display("FAIL sleep_before_reset: got reached=%0d req=%b clr=%b expected 1 1 1", reached, pwr_req2, clear2);
    else n_pass++;
    #2;
    sysreset_n = 1'b0;
    #1;
    n_checks++;
    if (lp_state2 !== 3'd0 || pwr_req2 !== 1'b0 || clear2 !== 1'b0 || timeout_err2 !== 1'b0) $display("FAIL async_reset_outputs: got state=%0d req=%b clr=%b err=%b expected all 0", lp_state2, pwr_req2, clear2, timeout_err2);
    else n_pass++;
    @(posedge clkclk);
    #1;
    sysreset_n = 1'b1;
    act2 = 1'b0; epu2 = 1'b0; ack2 = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    act = 1'b1; epu = 1'b1;
    for (int i = 0; i < ENTRY + 1; i++) tick();
    act = 1'b0;
    n_checks++;
    if (lp_state !== 3'd2) $display("FAIL tmo_in_req: got %0d expected 2", lp_state);
    else n_pass++;
`ifdef WEB1_LP_SEQ_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) tick();
    n_checks++;
    if (lp_state !== 3'd2 || pwr_req !== 1'b1 || timeout_err !== 1'b0) $display("FAIL tmo_before: got state=%0d req=%b err=%b expected 2 1 0", lp_state, pwr_req, timeout_err);
    else n_pass++;
    tick();
    n_checks++;
    if (lp_state !== 3'd0 || pwr_req !== 1'b0 || timeout_err !== 1'b1) $display("FAIL tmo_fire: got state=%0d req=%b err=%b expected 0 0 1", lp_state, pwr_req, timeout_err);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b expected 1", timeout_err);
    else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0) $display("FAIL tmo_clear: got %b expected 0", timeout_err);
    else n_pass++;
`else
    for (int i = 0; i < TMO + 45; i++) tick();
    n_checks++;
    if (lp_state !== 3'd2 || pwr_req !== 1'b1 || timeout_err !== 1'b0) $display("FAIL no_tmo_wait: got state=%0d req=%b err=%b expected 2 1 0", lp_state, pwr_req, timeout_err);
    else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0 || lp_state !== 3'd2) $display("FAIL no_tmo_err_clr: got err=%b state=%0d expected 0 2", timeout_err, lp_state);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_entry(5);
    test_exit(3);
    for (int r = 0; r < 3; r++) begin
      test_entry($urandom_range(8, 1));
      test_exit($urandom_range(5, 1));
    end
    test_abort(8, 1'b1);
    for (int r = 0; r < 3; r++) begin
      test_abort($urandom_range(15, 1), 1'($urandom_range(1, 0)));
    end
    test_wake_in_req($urandom_range(6, 1));
    test_queue(0);
    for (int r = 0; r < 3; r++) begin
      test_queue($urandom_range(6, 0));
    end
    test_reset_in_sleep();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
